// File: rtl/fir_pkg.sv
// fir_pkg: shared types, default widths and rounding helpers for the serial FIR
// Contents: state_e (IDLE/ACCUM/OUTPUT), DEF_* width defaults, acc_width(),
// round_half_up(), sat_flag() and sat_round() (round-half-up followed by clamp).
package fir_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_e;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 16;
    localparam int DEF_FRAC_BITS = 15;
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction
    function automatic logic signed [63:0] round_half_up(input logic signed [63:0] acc, input int frac_bits);
        return frac_bits > 0 ? (acc + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits : acc;
    endfunction
    function automatic logic sat_flag(input logic signed [63:0] acc, input int frac_bits, input int data_w);
        logic signed [63:0] r;
        r = round_half_up(acc, frac_bits);
        return (r > (64'sd1 <<< (data_w - 1)) - 64'sd1) || (r < -(64'sd1 <<< (data_w - 1)));
    endfunction
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc, input int frac_bits, input int data_w);
        logic signed [63:0] r, hi, lo;
        r = round_half_up(acc, frac_bits);
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        return r > hi ? hi : r < lo ? lo : r;
    endfunction
endpackage

// File: rtl/fir_filter_serial_mac.sv
// fir_mac: registered signed multiply-accumulate with synchronous clear
// Ports: clk_i clock, rst_i sync active-high reset, clr_i zero the accumulator,
// en_i add a_i*b_i this cycle, a_i/b_i signed operands, acc_o running sum.
module fir_mac #(
    parameter int A_W = 17,
    parameter int B_W = 16,
    parameter int ACC_W = 40
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [A_W-1:0]   a_i,
    input  logic signed [B_W-1:0]   b_i,
    output logic signed [ACC_W-1:0] acc_o
);
    logic signed [A_W+B_W-1:0] prod;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    assign prod = a_i * b_i;
    always_comb acc_d = clr_i ? '0 : en_i ? acc_q + ACC_W'(prod) : acc_q;
    always_ff @(posedge clk_i) acc_q <= rst_i ? '0 : acc_d;
    assign acc_o = acc_q;
endmodule

// File: rtl/fir_filter_serial.sv
// fir_filter_serial: time-multiplexed FIR, one tap per clock through a shared MAC
// Ports: clock, reset_n (sync, active-high), in_valid/in_ready/in_data sample
// handshake, coef_we/coef_addr/coef_wdata coefficient writes (IDLE only),
// out_valid one-cycle pulse, out_data held result, out_sat saturation flag.
// Build option FIR_SYMMETRIC_EN folds the delay line for linear-phase filters.
module fir_filter_serial
    import fir_pkg::*;
#(
    parameter int TAPS = 31,
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int ACC_W = acc_width(DATA_W, COEF_W, TAPS)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATA_W-1:0]   in_data,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_wdata,
    output logic                       out_valid,
    output logic signed [DATA_W-1:0]   out_data,
    output logic                       out_sat
);
    localparam int IDX_W = $clog2(TAPS);
`ifdef FIR_SYMMETRIC_EN
    localparam int NACC = (TAPS + 1) / 2;
    localparam int MAC_A_W = DATA_W + 1;
`else
    localparam int NACC = TAPS;
    localparam int MAC_A_W = DATA_W;
`endif
    state_e state_q;
    logic [IDX_W-1:0] k_q;
    logic signed [DATA_W-1:0] d_q [TAPS];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [MAC_A_W-1:0] mac_a;
    logic signed [ACC_W-1:0] acc;
    logic out_valid_q, out_sat_q;
    logic signed [DATA_W-1:0] out_data_q;
    logic accept, coef_ok, last_tap;
    assign in_ready = state_q == IDLE;
    assign accept = in_valid && in_ready;
    // Only the coefficients the active mode actually reads are writable.
    assign coef_ok = coef_we && in_ready && (32'(coef_addr) < NACC);
    assign last_tap = k_q == IDX_W'(NACC - 1);
`ifdef FIR_SYMMETRIC_EN
    logic [IDX_W-1:0] k_mirror;
    assign k_mirror = IDX_W'(TAPS - 1) - k_q;
    // The centre tap of an odd-length filter pairs with itself and must not be doubled.
    assign mac_a = k_mirror == k_q ? MAC_A_W'(d_q[k_q]) : MAC_A_W'(d_q[k_q]) + MAC_A_W'(d_q[k_mirror]);
`else
    assign mac_a = d_q[k_q];
`endif
    fir_mac #(
        .A_W  (MAC_A_W),
        .B_W  (COEF_W),
        .ACC_W(ACC_W)
    ) u_mac (
        .clk_i(clock),
        .rst_i(reset_n),
        .clr_i(accept),
        .en_i (state_q == ACCUM),
        .a_i  (mac_a),
        .b_i  (coef_q[k_q]),
        .acc_o(acc)
    );
    always_ff @(posedge clock) begin
        if (reset_n) begin
            state_q <= IDLE;
            k_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_sat_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                d_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            if (coef_ok) coef_q[coef_addr] <= coef_wdata;
            case (state_q)
                IDLE: if (accept) begin
                    for (int i = TAPS - 1; i > 0; i--) d_q[i] <= d_q[i-1];
                    d_q[0] <= in_data;
                    k_q <= '0;
                    state_q <= ACCUM;
                end
                ACCUM: begin
                    k_q <= last_tap ? '0 : k_q + 1'b1;
                    if (last_tap) state_q <= OUTPUT;
                end
                OUTPUT: begin
                    out_data_q <= DATA_W'(sat_round(64'(acc), FRAC_BITS, DATA_W));
                    out_sat_q <= sat_flag(64'(acc), FRAC_BITS, DATA_W);
                    out_valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign out_sat = out_sat_q;
endmodule
